// File: rtl/ps2_mouse_pointer_tracker.sv
// PS/2 mouse packet assembler and clamped absolute pointer tracker.
// Optional pointer acceleration is enabled by defining POINTER_ACCEL_EN.
module ps2_mouse_pointer_tracker #(
  parameter int SCREEN_WIDTH       = 240,
  parameter int SCREEN_HEIGHT      = 320,
  parameter int BITS_SCREEN_WIDTH  = 8,
  parameter int BITS_SCREEN_HEIGHT = 9,
  parameter int TIMEOUT_CYCLES     = 50000
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [7:0]                    rxData,
  input  logic                          rxValid,
  output logic [BITS_SCREEN_WIDTH-1:0]  xPosPointer,
  output logic [BITS_SCREEN_HEIGHT-1:0] yPosPointer,
  output logic                          leftButton,
  output logic                          rightButton,
  output logic                          positionCheck,
  output logic                          packetValid
);

  localparam int SUM_W = ((BITS_SCREEN_WIDTH > BITS_SCREEN_HEIGHT) ?
                          BITS_SCREEN_WIDTH : BITS_SCREEN_HEIGHT) + 2;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [SUM_W-1:0] X_MAX    = SUM_W'(SCREEN_WIDTH - 1);
  localparam logic signed [SUM_W-1:0] Y_MAX    = SUM_W'(SCREEN_HEIGHT - 1);
`ifdef POINTER_ACCEL_EN
  localparam logic signed [SUM_W-1:0] ACCEL_LIM = SUM_W'(8);
`endif

  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, UPDATE} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                timeoutCnt;
  // Packed status subset: {yOvf, xOvf, ySign, xSign, right, left}
  logic [5:0]                      status;
  logic [7:0]                      byte1;
  logic [7:0]                      byte2;

  logic signed [SUM_W-1:0]         dxExt, dyExt, xSum, ySum;
  logic [BITS_SCREEN_WIDTH-1:0]    xNext;
  logic [BITS_SCREEN_HEIGHT-1:0]   yNext;

  always_comb begin
    dxExt = '0;
    dyExt = '0;
    if (!status[4]) dxExt = {{(SUM_W-8){status[2]}}, byte1};
    if (!status[5]) dyExt = {{(SUM_W-8){status[3]}}, byte2};
`ifdef POINTER_ACCEL_EN
    if (dxExt > ACCEL_LIM || dxExt < -ACCEL_LIM) dxExt = dxExt <<< 1;
    if (dyExt > ACCEL_LIM || dyExt < -ACCEL_LIM) dyExt = dyExt <<< 1;
`endif
    xSum = $signed({{(SUM_W-BITS_SCREEN_WIDTH){1'b0}}, xPosPointer}) + dxExt;
    ySum = $signed({{(SUM_W-BITS_SCREEN_HEIGHT){1'b0}}, yPosPointer}) + dyExt;

    if (xSum[SUM_W-1])     xNext = '0;
    else if (xSum > X_MAX) xNext = X_MAX[BITS_SCREEN_WIDTH-1:0];
    else                   xNext = xSum[BITS_SCREEN_WIDTH-1:0];

    if (ySum[SUM_W-1])     yNext = '0;
    else if (ySum > Y_MAX) yNext = Y_MAX[BITS_SCREEN_HEIGHT-1:0];
    else                   yNext = ySum[BITS_SCREEN_HEIGHT-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= BYTE0;
      timeoutCnt    <= '0;
      status        <= '0;
      byte1         <= '0;
      byte2         <= '0;
      xPosPointer   <= BITS_SCREEN_WIDTH'(SCREEN_WIDTH / 2);
      yPosPointer   <= BITS_SCREEN_HEIGHT'(SCREEN_HEIGHT / 2);
      leftButton    <= 1'b0;
      rightButton   <= 1'b0;
      positionCheck <= 1'b0;
      packetValid   <= 1'b0;
    end else begin
      packetValid   <= 1'b0;
      positionCheck <= 1'b0;
      case (state)
        BYTE0: begin
          timeoutCnt <= '0;
          if (rxValid && rxData[3]) begin
            status <= {rxData[7:4], rxData[1:0]};
            state  <= BYTE1;
          end
        end
        BYTE1, BYTE2: begin
          if (rxValid) begin
            timeoutCnt <= '0;
            if (state == BYTE1) begin
              byte1 <= rxData;
              state <= BYTE2;
            end else begin
              byte2 <= rxData;
              state <= UPDATE;
            end
          end else if (timeoutCnt == CNT_LAST) begin
            timeoutCnt <= '0;
            state      <= BYTE0;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        UPDATE: begin
          xPosPointer   <= xNext;
          yPosPointer   <= yNext;
          leftButton    <= status[0];
          rightButton   <= status[1];
          positionCheck <= status[0] & ~leftButton;
          packetValid   <= 1'b1;
          timeoutCnt    <= '0;
          // A byte arriving during the update cycle is handled as BYTE0 input.
          if (rxValid && rxData[3]) begin
            status <= {rxData[7:4], rxData[1:0]};
            state  <= BYTE1;
          end else begin
            state  <= BYTE0;
          end
        end
        default: state <= BYTE0;
      endcase
    end
  end

endmodule
